// File: rtl/instruction_fetch.sv
// Instruction fetch front end: issues word-aligned fetches to a negedge-sampled
// instruction memory, buffers returned words with their addresses in a small
// FIFO, and hands them to decode over a valid/ready handshake. Branch redirects
// flush everything buffered or in flight and restart fetching at the target.
module instruction_fetch #(
    parameter int ADDR_W   = 7,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_V    = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

    logic [ADDR_W-1:0] pc;
    logic              req_valid;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [31:0]       data_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];

    logic              pop;
    logic              issue;
    logic [CNT_W:0]    occupancy;
    logic [ADDR_W-1:0] target;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready;
    assign target      = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign instr       = data_q[rd_ptr];
    assign instr_pc    = pc_q[rd_ptr];

    // Entries the FIFO will hold once the current request lands; a new request
    // is only issued if it is guaranteed a free slot when it returns.
    assign occupancy = {1'b0, count} - (CNT_W + 1)'(pop) + (CNT_W + 1)'(req_valid);
    assign issue     = (occupancy < DEPTH_V);

    // Request side: redirect restarts at the target, otherwise issue sequentially
    // when the FIFO can absorb the result, else idle with the address held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC_V;
            imem_addr <= '0;
            req_valid <= 1'b0;
        end else if (redirect) begin
            imem_addr <= target;
            pc        <= target + WORD_STEP;
            req_valid <= 1'b1;
        end else if (issue) begin
            imem_addr <= pc;
            pc        <= pc + WORD_STEP;
            req_valid <= 1'b1;
        end else begin
            req_valid <= 1'b0;
        end
    end

    // FIFO bookkeeping: a redirect empties the queue and drops any pop or capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (redirect) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (req_valid) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(req_valid) - CNT_W'(pop);
        end
    end

    // FIFO storage: capture the returned word with the address that fetched it;
    // cleared on reset so the head reads zero until the first capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (req_valid && !redirect) begin
            data_q[wr_ptr] <= imem_data;
            pc_q[wr_ptr]   <= imem_addr;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: two instances (RESET_PC 0 and 120), each with a
// negedge-sampled big-endian byte memory model, driven by per-cycle vector tables.
module tb_instruction_fetch;

    typedef struct {
        logic        ready;
        logic        redir;
        logic [6:0]  rpc;
        logic        valid;
        logic [31:0] instr;
        logic [6:0]  pc;
        logic [6:0]  addr;
    } vec_t;

    logic        clk = 1'b0;

    logic        reset_a = 1'b1;
    logic [6:0]  imem_addr_a;
    logic [31:0] imem_data_a = '0;
    logic [31:0] instr_a;
    logic [6:0]  instr_pc_a;
    logic        instr_valid_a;
    logic        instr_ready_a = 1'b1;
    logic        redirect_a = 1'b0;
    logic [6:0]  redirect_pc_a = '0;

    logic        reset_b = 1'b1;
    logic [6:0]  imem_addr_b;
    logic [31:0] imem_data_b = '0;
    logic [31:0] instr_b;
    logic [6:0]  instr_pc_b;
    logic        instr_valid_b;
    logic        instr_ready_b = 1'b1;
    logic        redirect_b = 1'b0;
    logic [6:0]  redirect_pc_b = '0;

    logic [7:0]  mem_a [128];
    logic [7:0]  mem_b [128];

    int checks = 0;
    int errors = 0;

    vec_t t1 [15];
    vec_t t2 [10];
    vec_t t3 [4];

    instruction_fetch #(.ADDR_W(7), .DEPTH(2), .RESET_PC(0)) dut_a (
        .clk         (clk),
        .reset       (reset_a),
        .imem_addr   (imem_addr_a),
        .imem_data   (imem_data_a),
        .instr       (instr_a),
        .instr_pc    (instr_pc_a),
        .instr_valid (instr_valid_a),
        .instr_ready (instr_ready_a),
        .redirect    (redirect_a),
        .redirect_pc (redirect_pc_a)
    );

    instruction_fetch #(.ADDR_W(7), .DEPTH(2), .RESET_PC(120)) dut_b (
        .clk         (clk),
        .reset       (reset_b),
        .imem_addr   (imem_addr_b),
        .imem_data   (imem_data_b),
        .instr       (instr_b),
        .instr_pc    (instr_pc_b),
        .instr_valid (instr_valid_b),
        .instr_ready (instr_ready_b),
        .redirect    (redirect_b),
        .redirect_pc (redirect_pc_b)
    );

    always #5 clk = ~clk;

    // Memory models: sample the address on negedge, return bytes a..a+3 big-endian.
    always @(negedge clk) begin
        imem_data_a <= {mem_a[imem_addr_a], mem_a[imem_addr_a + 7'd1],
                        mem_a[imem_addr_a + 7'd2], mem_a[imem_addr_a + 7'd3]};
        imem_data_b <= {mem_b[imem_addr_b], mem_b[imem_addr_b + 7'd1],
                        mem_b[imem_addr_b + 7'd2], mem_b[imem_addr_b + 7'd3]};
    end

    task automatic put_word(input bit sel_b, input int a, input logic [31:0] d);
        for (int k = 0; k < 4; k++) begin
            if (sel_b) mem_b[(a + k) % 128] = d[31 - 8*k -: 8];
            else       mem_a[(a + k) % 128] = d[31 - 8*k -: 8];
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_row(input vec_t v, input bit sel_b, input string tag, input int idx);
        if (sel_b) begin
            instr_ready_b = v.ready;
            redirect_b    = v.redir;
            redirect_pc_b = v.rpc;
        end else begin
            instr_ready_a = v.ready;
            redirect_a    = v.redir;
            redirect_pc_a = v.rpc;
        end
        @(posedge clk);
        #1;
        check($sformatf("%s[%0d].valid", tag, idx),
              32'(sel_b ? instr_valid_b : instr_valid_a), 32'(v.valid));
        check($sformatf("%s[%0d].imem_addr", tag, idx),
              32'(sel_b ? imem_addr_b : imem_addr_a), 32'(v.addr));
        if (v.valid) begin
            check($sformatf("%s[%0d].instr", tag, idx),
                  sel_b ? instr_b : instr_a, v.instr);
            check($sformatf("%s[%0d].instr_pc", tag, idx),
                  32'(sel_b ? instr_pc_b : instr_pc_a), 32'(v.pc));
        end
    endtask

    initial begin
        // Memory contents
        for (int w = 0; w < 128; w += 4) begin
            put_word(1'b0, w, 32'hC0DE_0000 | 32'(w));
            put_word(1'b1, w, 32'h0);
        end
        put_word(1'b0, 0,  32'h8DA1_0000);
        put_word(1'b0, 4,  32'h8DA2_0001);
        put_word(1'b0, 8,  32'h0022_1820);
        put_word(1'b0, 40, 32'h11AD_FFF8);
        put_word(1'b1, 120, 32'h0000_000A);
        put_word(1'b1, 124, 32'h0000_000B);
        put_word(1'b1, 0,   32'h0000_000C);

        // Stream, stall, redirects (incl. held redirect with pop), then refill
        t1[0]  = '{1'b1, 1'b0, 7'd0,  1'b0, 32'h0,         7'd0,  7'd0};
        t1[1]  = '{1'b1, 1'b0, 7'd0,  1'b1, 32'h8DA1_0000, 7'd0,  7'd4};
        t1[2]  = '{1'b1, 1'b0, 7'd0,  1'b1, 32'h8DA2_0001, 7'd4,  7'd8};
        t1[3]  = '{1'b1, 1'b0, 7'd0,  1'b1, 32'h0022_1820, 7'd8,  7'd12};
        t1[4]  = '{1'b0, 1'b0, 7'd0,  1'b1, 32'h0022_1820, 7'd8,  7'd12};
        t1[5]  = '{1'b0, 1'b0, 7'd0,  1'b1, 32'h0022_1820, 7'd8,  7'd12};
        t1[6]  = '{1'b0, 1'b1, 7'd41, 1'b0, 32'h0,         7'd0,  7'd40};
        t1[7]  = '{1'b1, 1'b0, 7'd0,  1'b1, 32'h11AD_FFF8, 7'd40, 7'd44};
        t1[8]  = '{1'b1, 1'b0, 7'd0,  1'b1, 32'hC0DE_002C, 7'd44, 7'd48};
        t1[9]  = '{1'b1, 1'b1, 7'd16, 1'b0, 32'h0,         7'd0,  7'd16};
        t1[10] = '{1'b1, 1'b1, 7'd32, 1'b0, 32'h0,         7'd0,  7'd32};
        t1[11] = '{1'b1, 1'b0, 7'd0,  1'b1, 32'hC0DE_0020, 7'd32, 7'd36};
        t1[12] = '{1'b1, 1'b0, 7'd0,  1'b1, 32'hC0DE_0024, 7'd36, 7'd40};
        t1[13] = '{1'b0, 1'b0, 7'd0,  1'b1, 32'hC0DE_0024, 7'd36, 7'd40};
        t1[14] = '{1'b0, 1'b0, 7'd0,  1'b1, 32'hC0DE_0024, 7'd36, 7'd40};

        // After reset: first word, five stalled cycles, then release
        t2[0] = '{1'b1, 1'b0, 7'd0, 1'b0, 32'h0,         7'd0,  7'd0};
        t2[1] = '{1'b0, 1'b0, 7'd0, 1'b1, 32'h8DA1_0000, 7'd0,  7'd4};
        for (int i = 2; i < 7; i++)
            t2[i] = '{1'b0, 1'b0, 7'd0, 1'b1, 32'h8DA1_0000, 7'd0, 7'd4};
        t2[7] = '{1'b1, 1'b0, 7'd0, 1'b1, 32'h8DA2_0001, 7'd4,  7'd8};
        t2[8] = '{1'b1, 1'b0, 7'd0, 1'b1, 32'h0022_1820, 7'd8,  7'd12};
        t2[9] = '{1'b1, 1'b0, 7'd0, 1'b1, 32'hC0DE_000C, 7'd12, 7'd16};

        // RESET_PC=120: address wraps 124 -> 0
        t3[0] = '{1'b1, 1'b0, 7'd0, 1'b0, 32'h0,  7'd0,   7'd120};
        t3[1] = '{1'b1, 1'b0, 7'd0, 1'b1, 32'hA,  7'd120, 7'd124};
        t3[2] = '{1'b1, 1'b0, 7'd0, 1'b1, 32'hB,  7'd124, 7'd0};
        t3[3] = '{1'b1, 1'b0, 7'd0, 1'b1, 32'hC,  7'd0,   7'd4};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset.valid",     32'(instr_valid_a), 32'h0);
        check("reset.instr",     instr_a,            32'h0);
        check("reset.instr_pc",  32'(instr_pc_a),    32'h0);
        check("reset.imem_addr", 32'(imem_addr_a),   32'h0);
        reset_a = 1'b0;

        for (int i = 0; i < 15; i++) apply_row(t1[i], 1'b0, "stream", i);

        // Asynchronous reset with the FIFO full: outputs clear without a clock edge
        reset_a = 1'b1;
        #1;
        check("async_reset.valid",     32'(instr_valid_a), 32'h0);
        check("async_reset.instr",     instr_a,            32'h0);
        check("async_reset.instr_pc",  32'(instr_pc_a),    32'h0);
        check("async_reset.imem_addr", 32'(imem_addr_a),   32'h0);
        repeat (2) @(posedge clk);
        #1;
        instr_ready_a = 1'b1;
        redirect_a    = 1'b0;
        reset_a       = 1'b0;

        for (int i = 0; i < 10; i++) apply_row(t2[i], 1'b0, "stall", i);

        // Second instance starting near the top of the address space
        reset_b = 1'b0;
        for (int i = 0; i < 4; i++) apply_row(t3[i], 1'b1, "wrap", i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch-side initiator for the 32-bit CPU's byte-addressed instruction memory.
- Generates word-aligned fetch addresses and captures returned instruction words into a small FIFO.
- Presents instructions to decode with a valid/ready handshake and handles branch redirects with a flush.
- Memory interface contract: memory samples `imem_addr` on negedge `clk` and drives `imem_data` = bytes [a..a+3], big-endian, held until the next negedge.

Parameters:
- ADDR_W, 7, width of the byte address (128-byte instruction space).
- DEPTH, 2, instruction FIFO entries; legal values are powers of two, 2 and above.
- RESET_PC, 0, first fetch address after reset (word aligned).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  ADDR_W  byte address presented to instruction memory; registered.
- imem_data  input  32  instruction word returned by memory.
- instr  output  32  instruction at FIFO head.
- instr_pc  output  ADDR_W  byte address of `instr`.
- instr_valid  output  1  FIFO non-empty.
- instr_ready  input  1  decode accepts head this cycle.
- redirect  input  1  branch/jump taken; flush and refetch.
- redirect_pc  input  ADDR_W  redirect target; bits [1:0] forced to 0.

Behaviour:
- State registers:
  - `pc`: next address to request.
  - `imem_addr`: address currently presented to memory.
  - `req_valid`: `imem_addr` is a live request.
  - FIFO storage and `count`.
- Reset (async, immediate): pc=RESET_PC, imem_addr=0, req_valid=0, count=0, FIFO pointers=0.
  - Outputs during and just after reset: instr_valid=0, instr=0, instr_pc=0.
- Latency: a request issued at posedge N is captured at posedge N+1 (memory updates in between on negedge). It is visible on `instr` and `instr_valid` after posedge N+1. First instruction is valid 2 posedges after reset deasserts.
- pop = instr_valid & instr_ready; the head is removed at the posedge.
- Capture: if req_valid, push {imem_addr, imem_data} at the posedge. Push and pop in the same cycle are both legal; count is unchanged.
- Issue condition: (count - pop + req_valid) < DEPTH.
  - When true: imem_addr<=pc, pc<=pc+4, req_valid<=1.
  - When false: req_valid<=0; pc and imem_addr hold.
  - The condition guarantees the FIFO never overflows. With DEPTH=2 the block sustains 1 instruction per cycle while `instr_ready` stays high.
- Address arithmetic is modulo 2^ADDR_W: pc 124 + 4 wraps to 0 with ADDR_W=7. No error is flagged.
- Redirect (highest priority) at the posedge:
  - FIFO cleared (count=0, pointers reset).
  - In-flight capture discarded.
  - Any pop in that cycle is ignored.
  - imem_addr<=redirect_pc&~3, pc<=(redirect_pc&~3)+4, req_valid<=1.
  - The target instruction is valid 1 posedge later; no stale instruction is ever presented after a redirect.
- Back-to-back redirects: the last one wins; each cycle repeats the flush.
- Stall (instr_ready=0): instr, instr_pc and instr_valid hold stable until popped. imem_addr may hold a stale address while req_valid=0; the captured value is ignored.
- instr and instr_pc are driven from the FIFO head. When the FIFO is empty they read the last written or reset contents; they are don't-care when instr_valid=0.
- No combinational path from instr_ready or redirect to imem_addr.

Test Plan:
- Reset release, instr_ready=1, memory preloaded with 0x8DA10000@0, 0x8DA20001@4, 0x00221820@8 -> instr_valid rises at 2nd posedge; instr/instr_pc = 0x8DA10000/0, 0x8DA20001/4, 0x00221820/8 on consecutive cycles.
- Hold instr_ready=0 for 5 cycles after the first valid -> instr stays 0x8DA10000/0, count reaches 2, imem_addr stops advancing. Releasing ready yields pc 4, 8, 12 with none skipped or duplicated.
- Assert redirect with redirect_pc=41 while the FIFO holds 2 entries -> next posedge instr_valid=0, imem_addr=40. One posedge later instr=0x11ADFFF8, instr_pc=40.
- Start RESET_PC=120 (words 0xA,0xB,0xC at 120,124,0), ready=1 -> instr_pc sequence 120, 124, 0; instr 0xA, 0xB, 0xC.
- Assert reset mid-stream with the FIFO full -> instr_valid=0 immediately, no posedge needed. After release the fetch restarts at RESET_PC with 2-cycle latency.
- Redirect and pop in the same cycle, redirect held 2 consecutive cycles (targets 16 then 32) -> only the instruction at 32 appears, with instr_pc=32.
